// File: rtl/seg_pkg.sv
// Shared types and the seven-segment encoder for the counter/scanner slice.
package seg_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] digit_t;

    localparam seg7_t  SEG_BLANK = 7'h00;
    localparam digit_t DEC_MAX   = 4'd9;
    localparam digit_t HEX_MAX   = 4'd15;

    // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active high.
    function automatic seg7_t hex7(input digit_t d);
        seg7_t s;
        case (d)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/updown_digit.sv
// One up/down counter digit; chained through cin_i/cout_o to form a multi-digit counter.
module updown_digit
    import seg_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   en_i,
    input  logic   up_i,
    input  digit_t max_i,
    input  logic   cin_i,
    output digit_t digit_o,
    output logic   cout_o
);

    digit_t r_digit;
    logic   w_at_limit;

    assign w_at_limit = up_i ? (r_digit == max_i) : (r_digit == 4'd0);
    assign cout_o     = cin_i & w_at_limit;
    assign digit_o    = r_digit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_digit <= 4'd0;
        end else if (clear_i) begin
            r_digit <= 4'd0;
        end else if (en_i && cin_i) begin
            if (up_i) begin
                r_digit <= w_at_limit ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= w_at_limit ? max_i : r_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_counter.sv
// Hex/decimal up/down counter with a multiplexed seven-segment scanner and a rotating LED bar.
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int LEDS     = 16,
    parameter int TICK_DIV = 4_000_000,
    parameter int SCAN_DIV = 2048
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  up_i,
    input  logic                  dec_mode_i,
    input  logic                  blank_lz_i,
    input  logic                  led_dir_i,
    input  logic                  btn_i,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [LEDS-1:0]       leds_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     dig_sel_o
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(DIGITS);

    logic [TICK_W-1:0] r_tick_cnt;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic              w_tick;
    logic              w_scan_tick;
    logic              w_step;

    logic r_btn_meta, r_btn_sync, r_btn_sync_d;
    logic r_dec_meta, r_dec_sync, r_dec_sync_d;
    logic w_btn_edge;
    logic w_mode_change;
    logic w_clear;

    digit_t            w_max;
    digit_t            w_digits [DIGITS];
    logic [DIGITS:0]   w_carry;
    logic [DIGITS-1:0] w_upper_zero;

    logic [LEDS-1:0]   r_leds;
    logic              r_pending;
    logic              w_inject;

    logic [IDX_W-1:0]  r_scan_idx;
    logic [IDX_W-1:0]  w_idx_next;
    digit_t            w_sel_digit;
    seg7_t             w_sel_seg;
    seg7_t             r_seg;
    logic              r_dp;
    logic [DIGITS-1:0] r_dig_sel;

    assign w_tick      = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_scan_tick = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_step      = w_tick & run_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tick_cnt <= '0;
            r_scan_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_btn_meta   <= 1'b0;
            r_btn_sync   <= 1'b0;
            r_btn_sync_d <= 1'b0;
            r_dec_meta   <= 1'b0;
            r_dec_sync   <= 1'b0;
            r_dec_sync_d <= 1'b0;
        end else begin
            r_btn_meta   <= btn_i;
            r_btn_sync   <= r_btn_meta;
            r_btn_sync_d <= r_btn_sync;
            r_dec_meta   <= dec_mode_i;
            r_dec_sync   <= r_dec_meta;
            r_dec_sync_d <= r_dec_sync;
        end
    end

    assign w_btn_edge    = r_btn_sync & ~r_btn_sync_d;
    assign w_mode_change = r_dec_sync ^ r_dec_sync_d;
    // A mode change wipes the count so no digit is ever left above the new maximum.
    assign w_clear       = clear_i | w_mode_change;
    assign w_max         = r_dec_sync ? DEC_MAX : HEX_MAX;
    assign w_carry[0]    = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        updown_digit u_digit (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (w_clear),
            .en_i    (w_step),
            .up_i    (up_i),
            .max_i   (w_max),
            .cin_i   (w_carry[i]),
            .digit_o (w_digits[i]),
            .cout_o  (w_carry[i+1])
        );
        assign count_o[4*i +: 4] = w_digits[i];
        assign w_upper_zero[i]   = (count_o[4*DIGITS-1:4*i] == '0);
    end

    // A press coinciding with a step goes straight into the bar instead of pending.
    assign w_inject = r_pending | w_btn_edge;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_leds    <= '0;
            r_pending <= 1'b0;
        end else if (w_step) begin
            r_pending <= 1'b0;
            if (led_dir_i) begin
                r_leds <= {r_leds[LEDS-2:0], r_leds[LEDS-1] | w_inject};
            end else begin
                r_leds <= {r_leds[0] | w_inject, r_leds[LEDS-1:1]};
            end
        end else if (w_btn_edge) begin
            r_pending <= 1'b1;
        end
    end

    assign w_idx_next  = !w_scan_tick ? r_scan_idx :
                         (r_scan_idx == IDX_W'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
    assign w_sel_digit = w_digits[w_idx_next];
    assign w_sel_seg   = (blank_lz_i && (w_idx_next != '0) && w_upper_zero[w_idx_next])
                         ? SEG_BLANK : hex7(w_sel_digit);

    // Pins are driven from the upcoming index so they move on the same edge as the index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scan_idx <= '0;
            r_seg      <= SEG_BLANK;
            r_dp       <= 1'b0;
            r_dig_sel  <= {{(DIGITS-1){1'b0}}, 1'b1};
        end else begin
            r_scan_idx <= w_idx_next;
            r_seg      <= w_sel_seg;
            r_dp       <= (w_idx_next == '0) & ~run_i;
            r_dig_sel  <= {{(DIGITS-1){1'b0}}, 1'b1} << w_idx_next;
        end
    end

    assign leds_o    = r_leds;
    assign seg_o     = r_seg;
    assign dp_o      = r_dp;
    assign dig_sel_o = r_dig_sel;

endmodule
